// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: 640x480@60 raster counters for the drawing objects, plus
// re-alignment of sync/blank to the registered mux pixel and RGB332 -> 4-4-4 expansion.
module vga_pixel_sink #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        pixelEn,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = 3 * PIPE_DELAY;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic          hsRaw;
    logic          vsRaw;
    logic          visRaw;
    logic [DW-1:0] delayLine;
    logic [DW-1:0] delayNext;
    logic          visAligned;

    assign hsRaw  = !((pixelX >= HS_START) && (pixelX < HS_END));
    assign vsRaw  = !((pixelY >= VS_START) && (pixelY < VS_END));
    assign visRaw = (pixelX < H_VIS) && (pixelY < V_VIS);

    // Each stage is {hs, vs, vis}; the top stage drives the sync/blank outputs directly.
    generate
        if (PIPE_DELAY == 1) begin : g_single
            assign delayNext = {hsRaw, vsRaw, visRaw};
        end else begin : g_multi
            assign delayNext = {delayLine[DW-4:0], hsRaw, vsRaw, visRaw};
        end
    endgenerate

    // Visibility that lands in the output stage on this edge, so colour matches blankN.
    assign visAligned = delayNext[DW-3];

    assign hSync  = delayLine[DW-1];
    assign vSync  = delayLine[DW-2];
    assign blankN = delayLine[DW-3];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pixelX       <= '0;
            pixelY       <= '0;
            startOfFrame <= 1'b0;
        end else begin
            startOfFrame <= 1'b0;
            if (pixelEn) begin
                if (pixelX == H_LAST) begin
                    pixelX <= '0;
                    if (pixelY == V_LAST) begin
                        pixelY       <= '0;
                        startOfFrame <= 1'b1;
                    end else begin
                        pixelY <= pixelY + 11'd1;
                    end
                end else begin
                    pixelX <= pixelX + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            delayLine <= {PIPE_DELAY{3'b110}};
        end else if (pixelEn) begin
            delayLine <= delayNext;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (pixelEn) begin
            if (visAligned) begin
                red   <= {RGBIn[7:5], RGBIn[7]};
                green <= {RGBIn[4:2], RGBIn[4]};
                blue  <= {RGBIn[1:0], RGBIn[1:0]};
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Scoreboard bench for vga_pixel_sink: the driver pushes the expected output set per clock,
// a negedge monitor pops and compares; directed checks cover line/frame timing and reset.
module tb_vga_pixel_sink;

    // Full horizontal timing; vertical shrunk so whole frames fit the cycle budget.
    localparam int VV    = 8;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 3;
    localparam int V_TOT = 15;
    localparam int H_TOT = 800;
    localparam int FRAME = 12000;
    localparam int PD    = 2;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } obs_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        pixelEn = 1'b0;
    logic [7:0]  RGBIn = 8'h00;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, hSync, vSync, blankN;
    logic [3:0]  red, green, blue;

    always #5 clk = ~clk;

    vga_pixel_sink #(
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .PIPE_DELAY(PD)
    ) dut (
        .clk(clk), .resetN(resetN), .pixelEn(pixelEn), .RGBIn(RGBIn),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .red(red), .green(green), .blue(blue),
        .hSync(hSync), .vSync(vSync), .blankN(blankN)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    obs_t sb_q[$];

    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                a = '{x: pixelX, y: pixelY, sof: startOfFrame, hs: hSync, vs: vSync,
                      bl: blankN, r: red, g: green, b: blue};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got x=%0d y=%0d sof=%b hs=%b vs=%b blankN=%b rgb=%h%h%h required x=%0d y=%0d sof=%b hs=%b vs=%b blankN=%b rgb=%h%h%h",
                             $time, a.x, a.y, a.sof, a.hs, a.vs, a.bl, a.r, a.g, a.b,
                             e.x, e.y, e.sof, e.hs, e.vs, e.bl, e.r, e.g, e.b);
                end
            end
        end
    end

    // Reference model
    int         m_x, m_y;
    obs_t       m_o;
    logic [2:0] hist[$];

    task automatic model_reset();
        m_x = 0;
        m_y = 0;
        m_o = '{x: 11'd0, y: 11'd0, sof: 1'b0, hs: 1'b1, vs: 1'b1, bl: 1'b0,
                r: 4'd0, g: 4'd0, b: 4'd0};
        hist.delete();
    endtask

    task automatic model_step(input logic en, input logic [7:0] rgb);
        logic [2:0] raw;
        logic [2:0] al;
        if (!resetN) begin
            model_reset();
        end else begin
            m_o.sof = 1'b0;
            if (en) begin
                raw[2] = !(m_x >= 656 && m_x < 752);
                raw[1] = !(m_y >= VV + VF && m_y < VV + VF + VS);
                raw[0] = (m_x < 640) && (m_y < VV);
                hist.push_back(raw);
                if (hist.size() >= PD) begin
                    al = hist.pop_front();
                    m_o.hs = al[2];
                    m_o.vs = al[1];
                    m_o.bl = al[0];
                    if (al[0]) begin
                        m_o.r = {rgb[7:5], rgb[7]};
                        m_o.g = {rgb[4:2], rgb[4]};
                        m_o.b = {rgb[1:0], rgb[1:0]};
                    end else begin
                        m_o.r = 4'd0;
                        m_o.g = 4'd0;
                        m_o.b = 4'd0;
                    end
                end
                if (m_x == H_TOT - 1) begin
                    m_x = 0;
                    if (m_y == V_TOT - 1) begin
                        m_y = 0;
                        m_o.sof = 1'b1;
                    end else begin
                        m_y = m_y + 1;
                    end
                end else begin
                    m_x = m_x + 1;
                end
                m_o.x = 11'(m_x);
                m_o.y = 11'(m_y);
            end
        end
    endtask

    // Observed-statistics accumulated on enabled edges
    int          hs_low, bl_low, vs_low, blank_rgb, sof_cnt, sof_wide, hist_ok;
    logic        prev_sof = 1'b0;
    logic        prev_hs = 1'b1;
    logic [10:0] xh1 = '0;
    logic [10:0] xh2 = '0;

    task automatic clear_stats();
        hs_low = 0; bl_low = 0; vs_low = 0; blank_rgb = 0; sof_cnt = 0; sof_wide = 0;
    endtask

    task automatic cycle(input logic en, input logic [7:0] rgb);
        pixelEn = en;
        RGBIn   = rgb;
        @(posedge clk);
        model_step(en, rgb);
        sb_q.push_back(m_o);
        #1;
        if (startOfFrame && prev_sof) sof_wide++;
        if (startOfFrame) sof_cnt++;
        prev_sof = startOfFrame;
        if (!resetN) begin
            hist_ok = 0;
            prev_hs = 1'b1;
        end else if (en) begin
            if (!hSync) hs_low++;
            if (!vSync) vs_low++;
            if (!blankN) bl_low++;
            if (!blankN && {red, green, blue} != 12'h000) blank_rgb++;
            if (!hSync && prev_hs && hist_ok >= 2) check("hsync_align_x", int'(xh2), 656);
            prev_hs = hSync;
            xh2 = xh1;
            xh1 = pixelX;
            hist_ok++;
        end
    endtask

    initial begin
        int n;
        model_reset();
        clear_stats();
        hist_ok = 0;

        repeat (3) cycle(1'b1, 8'hA9);
        check("rst_pixelX", int'(pixelX), 0);
        check("rst_hSync", int'(hSync), 1);
        check("rst_blankN", int'(blankN), 0);

        // A9 = 101_010_01 -> red 1011, green 0100 (MSB replicated), blue 0101
        resetN = 1'b1;
        cycle(1'b1, 8'hA9);
        check("blankN_after_1", int'(blankN), 0);
        cycle(1'b1, 8'hA9);
        check("blankN_after_2", int'(blankN), 1);
        check("red_A9", int'(red), 11);
        check("green_A9", int'(green), 4);
        check("blue_A9", int'(blue), 5);
        repeat (8) cycle(1'b1, 8'hA9);
        check("pixelX_10", int'(pixelX), 10);
        check("pixelY_10", int'(pixelY), 0);
        check("hSync_10", int'(hSync), 1);
        check("vSync_10", int'(vSync), 1);

        clear_stats();
        repeat (H_TOT) cycle(1'b1, 8'hFF);
        check("line_hsync_low", hs_low, 96);
        check("line_blank_low", bl_low, 160);
        check("line_blank_rgb", blank_rgb, 0);

        clear_stats();
        n = 0;
        while (sof_cnt == 0 && n < FRAME + 10) begin
            cycle(1'b1, 8'h5C);
            n++;
        end
        check("sof_seen", sof_cnt, 1);
        check("sof_pixelX", int'(pixelX), 0);
        check("sof_pixelY", int'(pixelY), 0);
        clear_stats();
        n = 0;
        while (sof_cnt == 0 && n < FRAME + 10) begin
            cycle(1'b1, 8'h5C);
            n++;
        end
        check("frame_period", n, FRAME);
        check("frame_vsync_low", vs_low, 1600);
        check("frame_blank_low", bl_low, FRAME - 640 * VV);
        check("frame_blank_rgb", blank_rgb, 0);
        check("frame_sof_wide", sof_wide, 0);

        repeat (2) cycle(1'b1, 8'hA9);
        check("vis_blankN", int'(blankN), 1);
        check("vis_red", int'(red), 11);
        check("vis_green", int'(green), 4);
        check("vis_blue", int'(blue), 5);
        cycle(1'b1, 8'h00);
        check("zero_rgb", int'({red, green, blue}), 0);

        clear_stats();
        n = 0;
        while (sof_cnt == 0 && n < 2 * FRAME + 20) begin
            cycle(1'b1, 8'h3C);
            n++;
            if (sof_cnt == 0) begin
                cycle(1'b0, 8'hC3);
                n++;
            end
        end
        check("tog_sof_high", int'(startOfFrame), 1);
        check("tog_sof_pixelX", int'(pixelX), 0);
        cycle(1'b0, 8'hC3);
        check("tog_sof_low_idle", int'(startOfFrame), 0);
        check("tog_hold_pixelX", int'(pixelX), 0);
        repeat (10) begin
            cycle(1'b1, 8'h3C);
            cycle(1'b0, 8'hC3);
        end
        check("tog_pixelX_10", int'(pixelX), 10);
        check("tog_sof_count", sof_cnt, 1);
        check("tog_sof_wide", sof_wide, 0);

        n = 0;
        while (!(m_x == 300 && m_y == 5) && n < 20000) begin
            cycle(1'b1, 8'h77);
            n++;
        end
        check("mid_pixelX", int'(pixelX), 300);
        check("mid_pixelY", int'(pixelY), 5);
        resetN = 1'b0;
        #1;
        sb_q.delete();
        model_reset();
        sb_q.push_back(m_o);
        check("async_pixelX", int'(pixelX), 0);
        check("async_pixelY", int'(pixelY), 0);
        check("async_hSync", int'(hSync), 1);
        check("async_vSync", int'(vSync), 1);
        check("async_blankN", int'(blankN), 0);
        check("async_rgb", int'({red, green, blue}), 0);
        check("async_sof", int'(startOfFrame), 0);
        repeat (3) cycle(1'b1, 8'h77);
        resetN = 1'b1;
        repeat (5) cycle(1'b1, 8'hA9);
        check("restart_pixelX", int'(pixelX), 5);
        check("restart_pixelY", int'(pixelY), 0);
        check("restart_blankN", int'(blankN), 1);

        repeat (2) cycle(1'b0, 8'h00);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
